// File: rtl/adder_tree_acc_ctrl_pkg.sv
// Shared types and helpers for the adder-tree accumulation controller:
// FSM state encoding, default widths and the accumulator-to-output clamp.
package adder_tree_acc_ctrl_pkg;

  localparam int DATA_WID_DEF  = 16;
  localparam int INPUT_NUM_DEF = 8;
  localparam int ACC_WID_DEF   = 24;
  localparam int MAX_BEATS_DEF = 64;
  localparam int CNT_WID_DEF   = $clog2(MAX_BEATS_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_t;

  // Clamps a sign-extended value into a dw-bit signed range and flags overflow.
  function automatic sat_t sat_clamp(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    hi = (64'sd1 <<< (dw - 32'sd1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 32'sd1));
    if (v > hi) begin
      r.ovf = 1'b1;
      r.val = hi;
    end else if (v < lo) begin
      r.ovf = 1'b1;
      r.val = lo;
    end else begin
      r.ovf = 1'b0;
      r.val = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_acc_ctrl_if.sv
// Control, input-beat and result handshakes of the adder-tree accumulation controller.
interface adder_tree_acc_ctrl_if
  import adder_tree_acc_ctrl_pkg::*;
#(
  parameter int DATA_WID  = DATA_WID_DEF,
  parameter int INPUT_NUM = INPUT_NUM_DEF,
  parameter int ACC_WID   = ACC_WID_DEF,
  parameter int CNT_WID   = CNT_WID_DEF
);

  logic                                start;
  logic [CNT_WID-1:0]                  cfg_beats;
  logic                                abort;
  logic                                busy;
  logic                                in_valid;
  logic                                in_ready;
  logic [INPUT_NUM-1:0][DATA_WID-1:0]  in_data;
  logic                                out_valid;
  logic                                out_ready;
  logic [ACC_WID-1:0]                  out_sum;
  logic [DATA_WID-1:0]                 out_sat;
  logic                                out_ovf;

  modport master (
    output start, cfg_beats, abort, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, out_sum, out_sat, out_ovf
  );

  modport slave (
    input  start, cfg_beats, abort, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, out_sum, out_sat, out_ovf
  );

endinterface

// File: rtl/adder_tree_acc_ctrl_adder_tree.sv
// Combinational pairwise adder tree; two's complement wrap at DATA_WID.
module adder_tree #(
  parameter int INPUT_NUM = 8,
  parameter int DATA_WID  = 24
) (
  input  logic [INPUT_NUM-1:0][DATA_WID-1:0] in_data,
  output logic [DATA_WID-1:0]                sum
);

  // Heap layout: leaves at [INPUT_NUM +: INPUT_NUM], node k sums children 2k and 2k+1.
  logic [DATA_WID-1:0] node_s [1:2*INPUT_NUM-1];

  // Reduce leaves towards the root, deepest level first.
  always_comb begin
    for (int k = 1; k < 2 * INPUT_NUM; k++) begin
      node_s[k] = '0;
    end
    for (int k = 0; k < INPUT_NUM; k++) begin
      node_s[INPUT_NUM + k] = in_data[k];
    end
    for (int k = INPUT_NUM - 1; k >= 1; k--) begin
      node_s[k] = node_s[2 * k] + node_s[2 * k + 1];
    end
  end

  assign sum = node_s[1];

endmodule

// File: rtl/adder_tree_acc_ctrl_chk.sv
// Protocol checks for the accumulation controller: legal beat count and result hold.
module adder_tree_acc_ctrl_chk #(
  parameter int MAX_BEATS = 64,
  parameter int CNT_WID   = 7,
  parameter int ACC_WID   = 24
) (
  input logic               clk,
  input logic               rst_n,
  input logic               idle,
  input logic               start,
  input logic [CNT_WID-1:0] cfg_beats,
  input logic               abort,
  input logic               out_valid,
  input logic               out_ready,
  input logic [ACC_WID-1:0] out_sum
);

  ap_cfg_beats: assert property (@(posedge clk) disable iff (!rst_n)
    (start && idle) |-> (int'(cfg_beats) <= MAX_BEATS))
    else $error("cfg_beats above MAX_BEATS at start");

  ap_result_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !abort) |=> (out_valid && $stable(out_sum)))
    else $error("result dropped or changed while stalled");

endmodule

// File: rtl/adder_tree_acc_ctrl.sv
// Sequences adder_tree over cfg_beats input beats, accumulating one signed sum that is
// presented full-width and saturated over a valid/ready result port.
module adder_tree_acc_ctrl
  import adder_tree_acc_ctrl_pkg::*;
#(
  parameter int DATA_WID  = DATA_WID_DEF,
  parameter int INPUT_NUM = INPUT_NUM_DEF,
  parameter int ACC_WID   = ACC_WID_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  parameter int CNT_WID   = $clog2(MAX_BEATS + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  adder_tree_acc_ctrl_if.slave bus
);

  state_t                            state_r, next_state_s;
  logic [ACC_WID-1:0]                acc_r, acc_next_s;
  logic [CNT_WID-1:0]                cnt_r, cnt_next_s;
  logic [CNT_WID-1:0]                beats_r, beats_next_s;
  logic [INPUT_NUM-1:0][ACC_WID-1:0] tree_in_s;
  logic [ACC_WID-1:0]                tree_sum_s;
  logic                              in_ready_s, beat_fire_s, last_beat_s;
  sat_t                              sat_s;
  logic                              busy_r, out_valid_r, out_ovf_r;
  logic [ACC_WID-1:0]                out_sum_r;
  logic [DATA_WID-1:0]               out_sat_r;

  // Sign-extend each element of the beat to accumulator width.
  always_comb begin
    tree_in_s = '0;
    for (int k = 0; k < INPUT_NUM; k++) begin
      tree_in_s[k] = {{(ACC_WID - DATA_WID){bus.in_data[k][DATA_WID-1]}}, bus.in_data[k]};
    end
  end

  adder_tree #(
    .INPUT_NUM (INPUT_NUM),
    .DATA_WID  (ACC_WID)
  ) u_tree (
    .in_data (tree_in_s),
    .sum     (tree_sum_s)
  );

  assign in_ready_s  = (state_r == ACCUM) && !bus.abort;
  assign beat_fire_s = bus.in_valid && in_ready_s;
  assign last_beat_s = beat_fire_s && (cnt_r == (beats_r - CNT_WID'(1)));

  // Next-state, accumulator and counter update.
  always_comb begin
    next_state_s = state_r;
    acc_next_s   = acc_r;
    cnt_next_s   = cnt_r;
    beats_next_s = beats_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          acc_next_s = '0;
          if (bus.cfg_beats == '0) begin
            next_state_s = DONE;
          end else begin
            next_state_s = ACCUM;
            beats_next_s = bus.cfg_beats;
            cnt_next_s   = '0;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        if (bus.abort) begin
          next_state_s = IDLE;
        end else if (beat_fire_s) begin
          acc_next_s   = acc_r + tree_sum_s;
          cnt_next_s   = cnt_r + CNT_WID'(1);
          next_state_s = last_beat_s ? DONE : ACCUM;
        end else begin
          next_state_s = ACCUM;
        end
      end
      DONE: begin
        if (bus.abort || bus.out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Saturation is taken on the value that will be held while in DONE.
  always_comb begin
    sat_s = sat_clamp(64'($signed(acc_next_s)), DATA_WID);
  end

  // State, datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      cnt_r       <= '0;
      beats_r     <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_sat_r   <= '0;
      out_ovf_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      acc_r       <= acc_next_s;
      cnt_r       <= cnt_next_s;
      beats_r     <= beats_next_s;
      busy_r      <= (next_state_s != IDLE);
      out_valid_r <= (next_state_s == DONE);
      if (next_state_s == DONE) begin
        out_sum_r <= acc_next_s;
        out_sat_r <= DATA_WID'(sat_s.val);
        out_ovf_r <= sat_s.ovf;
      end else begin
        out_sum_r <= '0;
        out_sat_r <= '0;
        out_ovf_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_ovf   = out_ovf_r;

  adder_tree_acc_ctrl_chk #(
    .MAX_BEATS (MAX_BEATS),
    .CNT_WID   (CNT_WID),
    .ACC_WID   (ACC_WID)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle      (state_r == IDLE),
    .start     (bus.start),
    .cfg_beats (bus.cfg_beats),
    .abort     (bus.abort),
    .out_valid (out_valid_r),
    .out_ready (bus.out_ready),
    .out_sum   (out_sum_r)
  );

endmodule

// File: tb/tb_adder_tree_acc_ctrl.sv
// Scoreboard bench for adder_tree_acc_ctrl: directed cases plus randomized reductions
// checked against an arithmetic reference model.
module tb_adder_tree_acc_ctrl;
  import adder_tree_acc_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int N  = 8;
  localparam int AW = 24;
  localparam int MB = 64;
  localparam int CW = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_tree_acc_ctrl_if #(.DATA_WID(DW), .INPUT_NUM(N), .ACC_WID(AW), .CNT_WID(CW)) bus ();

  adder_tree_acc_ctrl #(
    .DATA_WID (DW), .INPUT_NUM (N), .ACC_WID (AW), .MAX_BEATS (MB), .CNT_WID (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] sum;
    logic [DW-1:0] sat;
    logic          ovf;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] beat_buf [MB][N];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, wrapped to AW bits, then clamped to DW bits.
  function automatic exp_t model(input int beats);
    longint t = 0;
    longint lim, m, s, hi, lo;
    exp_t   e;
    for (int b = 0; b < beats; b++)
      for (int k = 0; k < N; k++)
        t += longint'($signed(beat_buf[b][k]));
    lim = longint'(1) <<< AW;
    m = t & (lim - 1);
    if (m >= lim / 2) m -= lim;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    e.ovf = (m > hi) || (m < lo);
    s = (m > hi) ? hi : ((m < lo) ? lo : m);
    e.sum = m[AW-1:0];
    e.sat = s[DW-1:0];
    return e;
  endfunction

  task automatic fill_const(input int beats, input logic [DW-1:0] v);
    for (int b = 0; b < beats; b++)
      for (int k = 0; k < N; k++)
        beat_buf[b][k] = v;
  endtask

  task automatic fill_rand(input int beats);
    for (int b = 0; b < beats; b++)
      for (int k = 0; k < N; k++)
        beat_buf[b][k] = DW'($urandom);
  endtask

  // Monitor: every result handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got out_sum 0x%0h with no expectation queued", bus.out_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", 64'(bus.out_sum), 64'(e.sum));
        chk("out_sat", 64'(bus.out_sat), 64'(e.sat));
        chk("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
      end
    end
  end

  // Presents one beat after gap bubbles and waits for acceptance; starts and ends at posedge+1.
  task automatic send_beat(input int b, input int gap, output bit ok, output bit pre_valid);
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    for (int k = 0; k < N; k++) bus.in_data[k] = beat_buf[b][k];
    ok = 1'b0;
    pre_valid = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        pre_valid = bus.out_valid;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      $display("FAIL beat_accept_timeout: beat %0d not accepted within 20 cycles", b);
      $fatal(1, "beat acceptance timeout");
    end
  endtask

  // One complete reduction with the result held unconsumed for hold cycles.
  task automatic do_run(input int beats, input int gap, input int hold);
    exp_t e;
    bit   ok, pre;
    e = model(beats);
    exp_q.push_back(e);
    bus.out_ready = (hold == 0);
    bus.cfg_beats = CW'(beats);
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int b = 0; b < beats; b++) begin
      send_beat(b, (gap < 0) ? int'($urandom_range(0, 2)) : gap, ok, pre);
      if (b == beats - 1) chk("valid_before_last_accept", 64'(pre), 64'd0);
    end
    @(negedge clk);
    chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    for (int h = 1; h < hold; h++) begin
      bus.start     = 1'b1;
      bus.cfg_beats = CW'(3);
      @(negedge clk);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_out_sum", 64'(bus.out_sum), 64'(e.sum));
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    if (hold > 0) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("idle_after_result_busy", 64'(bus.busy), 64'd0);
    chk("idle_after_result_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, pre;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.cfg_beats = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
    chk("reset_out_sum", 64'(bus.out_sum), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mixed small values, then saturation high, then saturation low.
    fill_const(1, 16'h00aa);
    beat_buf[0][0] = 16'h0001;
    do_run(1, 0, 0);
    fill_const(2, 16'h7fff);
    do_run(2, 1, 0);
    fill_const(1, 16'ha00a);
    do_run(1, 0, 0);

    // Stalled result with start pulses that must be ignored.
    fill_rand(1);
    do_run(1, 0, 5);

    // Zero-beat reduction.
    do_run(0, 0, 0);

    // Abort after the first of three beats, with a beat offered alongside abort.
    fill_rand(3);
    bus.cfg_beats = CW'(3);
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    send_beat(0, 0, ok, pre);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    fill_rand(1);
    do_run(1, 0, 0);

    // Asynchronous reset in the middle of an accumulation.
    fill_rand(4);
    bus.cfg_beats = CW'(4);
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    send_beat(0, 0, ok, pre);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 64'(bus.busy), 64'd0);
    chk("midrun_reset_in_ready", 64'(bus.in_ready), 64'd0);
    chk("midrun_reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrun_reset_out_sum", 64'(bus.out_sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized reductions: lengths up to MAX_BEATS, bubbles and result back-pressure.
    for (int r = 0; r < 30; r++) begin
      int beats;
      beats = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MB));
      fill_rand(beats);
      do_run(beats, -1, int'($urandom_range(0, 3)));
    end
    fill_rand(MB);
    do_run(MB, 0, 0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
